dmem_arbiter: RTL and testbench

Two-port request/acknowledge arbiter and access sequencer in front of the single-ported 16-bit data memory (address, data_write, mem_write, mem_read, data_read). Shares the memory between requester 0 (CPU load/store stage) and requester 1 (debug/DMA loader). Serialises one access at a time, holds mem_read for the configured read latency, and returns read data with a one-cycle ack pulse. Round-robin fairness by default.

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/dmem_arbiter_rr_arbiter2.sv | 34 +++
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// States, default widths, read-latency bound and requester ids.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int ADDR_W_DEF   = 16;
  localparam int DATA_W_DEF   = 16;
  localparam int READ_LAT_MAX = 3;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Combinational two-way winner select. DMEM_ARB_FIXED_PRIO_EN makes port 0
// always win and leaves the last-grant input unused.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic grant
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    valid = req0 | req1;
    grant = req0 ? P0 : P1;
  end
`else
  always_comb begin
    valid = req0 | req1;
    grant = P0;
    if (req0 && req1) begin
      // Contention: whoever was not served last goes next.
      grant = (last == P0) ? P1 : P0;
    end else if (req1) begin
      grant = P1;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the single-ported data memory.
// Round-robin by default; DMEM_ARB_FIXED_PRIO_EN selects fixed port-0 priority.
//
// Handshake: a requester raises req with we/addr/wdata and holds req until
// ack, a one-cycle pulse; read data is valid on rdata together with ack and
// holds until that port's next read. Inputs are latched at grant.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_write,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_data_read,
  output logic              busy,
  output logic              grant_id,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] LAT = 2'(READ_LAT);

  state_t     state;
  logic [1:0] cnt;
  logic       last;
  logic       arb_valid;
  logic       arb_grant;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign last = P1;
`endif

  rr_arbiter2 u_arb (
    .req0  (req0),
    .req1  (req1),
    .last  (last),
    .valid (arb_valid),
    .grant (arb_grant)
  );

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 2'd0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last           <= P1;
`endif
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      rdata0         <= '0;
      rdata1         <= '0;
      mem_address    <= '0;
      mem_data_write <= '0;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
      busy           <= 1'b0;
      grant_id       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            state          <= ISSUE;
            busy           <= 1'b1;
            grant_id       <= arb_grant;
            mem_address    <= (arb_grant == P1) ? addr1 : addr0;
            mem_data_write <= (arb_grant == P1) ? wdata1 : wdata0;
            mem_write      <= (arb_grant == P1) ? we1 : we0;
            mem_read       <= (arb_grant == P1) ? !we1 : !we0;
          end
        end
        ISSUE: begin
          if (mem_write) begin
            mem_write <= 1'b0;
            state     <= DONE;
            if (grant_id == P1) ack1 <= 1'b1;
            else                ack0 <= 1'b1;
          end else if (LAT == 2'd0) begin
            mem_read <= 1'b0;
            state    <= DONE;
            if (grant_id == P1) begin
              ack1   <= 1'b1;
              rdata1 <= mem_data_read;
            end else begin
              ack0   <= 1'b1;
              rdata0 <= mem_data_read;
            end
          end else begin
            state <= WAIT;
            cnt   <= 2'd1;
          end
        end
        WAIT: begin
          // cnt counts WAIT cycles; data is sampled at the end of the last.
          if (cnt == LAT) begin
            mem_read <= 1'b0;
            state    <= DONE;
            if (grant_id == P1) begin
              ack1   <= 1'b1;
              rdata1 <= mem_data_read;
            end else begin
              ack0   <= 1'b1;
              rdata0 <= mem_data_read;
            end
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
`ifndef DMEM_ARB_FIXED_PRIO_EN
          last  <= grant_id;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: READ_LAT=1 main instance plus
// READ_LAT=0 and READ_LAT=3 instances, each with its own memory model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] cyc = 16'd0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // ---------------- main DUT (READ_LAT=1) ----------------
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, mem_write, mem_read, busy, grant_id;
  logic [15:0] rdata0, rdata1, mem_address, mem_data_write, mem_data_read;
  logic [1:0]  dbg_state;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_address(mem_address), .mem_data_write(mem_data_write),
    .mem_write(mem_write), .mem_read(mem_read), .mem_data_read(mem_data_read),
    .busy(busy), .grant_id(grant_id), .dbg_state(dbg_state)
  );

  // ---------------- latency variants (port 0 only) ----------------
  logic        req_b, req_c, we_x;
  logic [15:0] addr_x, wdata_x;
  logic        ack_b0, ack_b1, ack_c0, ack_c1;
  logic [15:0] rdata_b0, rdata_b1, rdata_c0, rdata_c1;
  logic [15:0] b_addr, b_wdat, b_rdat, c_addr, c_wdat, c_rdat;
  logic        b_wr, b_rd, c_wr, c_rd, b_busy, c_busy, b_gid, c_gid;
  logic [1:0]  b_st, c_st;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(0)) dut_b (
    .clk(clk), .rst(rst),
    .req0(req_b), .we0(we_x), .addr0(addr_x), .wdata0(wdata_x), .ack0(ack_b0), .rdata0(rdata_b0),
    .req1(1'b0), .we1(1'b0), .addr1(16'h0), .wdata1(16'h0), .ack1(ack_b1), .rdata1(rdata_b1),
    .mem_address(b_addr), .mem_data_write(b_wdat), .mem_write(b_wr), .mem_read(b_rd),
    .mem_data_read(b_rdat), .busy(b_busy), .grant_id(b_gid), .dbg_state(b_st)
  );

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(3)) dut_c (
    .clk(clk), .rst(rst),
    .req0(req_c), .we0(we_x), .addr0(addr_x), .wdata0(wdata_x), .ack0(ack_c0), .rdata0(rdata_c0),
    .req1(1'b0), .we1(1'b0), .addr1(16'h0), .wdata1(16'h0), .ack1(ack_c1), .rdata1(rdata_c1),
    .mem_address(c_addr), .mem_data_write(c_wdat), .mem_write(c_wr), .mem_read(c_rd),
    .mem_data_read(c_rdat), .busy(c_busy), .grant_id(c_gid), .dbg_state(c_st)
  );

  // ---------------- memory models ----------------
  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  logic [15:0] mem_c [256];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 16'h0;
      mem_b[i] = 16'h0;
      mem_c[i] = 16'h0;
    end
  end

  always @(posedge clk) begin
    if (mem_write) mem_a[mem_address[7:0]] <= mem_data_write;
    if (b_wr)      mem_b[b_addr[7:0]]      <= b_wdat;
    if (c_wr)      mem_c[c_addr[7:0]]      <= c_wdat;
  end

  assign mem_data_read = mem_a[mem_address[7:0]];
  assign b_rdat        = mem_b[b_addr[7:0]];
  assign c_rdat        = mem_c[c_addr[7:0]];

  // ---------------- scoreboard ----------------
  // entry: {dut[1:0], port, is_read, rdata[15:0], ack_cycle[15:0]}
  logic [35:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [35:0] mk(input logic [1:0] d, input logic p, input logic rd,
                                     input logic [15:0] data, input logic [15:0] c);
    return {d, p, rd, data, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic pop(input logic [1:0] d, input logic p, input logic [15:0] rdat);
    logic [35:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ack actual dut=%0d port=%0d required none cyc=%0d", d, p, cyc);
    end else begin
      e = exp_q.pop_front();
      check("ack_id", {29'd0, d, p}, {29'd0, e[35:33]});
      check("ack_cycle", {16'd0, cyc}, {16'd0, e[15:0]});
      if (e[32]) check("ack_rdata", {16'd0, rdat}, {16'd0, e[31:16]});
    end
  endtask

  always @(negedge clk) begin
    check("rd_wr_exclusive", {31'd0, mem_write & mem_read}, 32'd0);
    if (ack0)   pop(2'd0, P0, rdata0);
    if (ack1)   pop(2'd0, P1, rdata1);
    if (ack_b0) pop(2'd1, P0, rdata_b0);
    if (ack_c0) pop(2'd2, P0, rdata_c0);
  end

  // ---------------- drivers ----------------
  task automatic drive0(input logic we, input logic [15:0] a, input logic [15:0] d, input bit hold);
    int n;
    req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack0 && n < 40);
    if (!ack0) begin checks++; errors++; $display("FAIL timeout_ack0 actual none required ack"); end
    if (!hold) req0 = 1'b0;
  endtask

  task automatic drive1(input logic we, input logic [15:0] a, input logic [15:0] d, input bit hold);
    int n;
    req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack1 && n < 40);
    if (!ack1) begin checks++; errors++; $display("FAIL timeout_ack1 actual none required ack"); end
    if (!hold) req1 = 1'b0;
  endtask

  task automatic drive_x(input int which, input logic we, input logic [15:0] a, input logic [15:0] d);
    int n;
    we_x = we; addr_x = a; wdata_x = d;
    if (which == 1) req_b = 1'b1; else req_c = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!((which == 1) ? ack_b0 : ack_c0) && n < 40);
    if (!((which == 1) ? ack_b0 : ack_c0)) begin
      checks++; errors++; $display("FAIL timeout_ack_lat actual none required ack");
    end
    req_b = 1'b0; req_c = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  logic [15:0] c;

  initial begin
    rst = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    req_b = 0; req_c = 0; we_x = 0; addr_x = 0; wdata_x = 0;
    repeat (3) @(negedge clk);

    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    check("rst_mem_ctl", {30'd0, mem_write, mem_read}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_address}, 32'd0);
    check("rst_rdata", {rdata0, rdata1}, 32'd0);
    check("rst_acks", {30'd0, ack0, ack1}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: port 0 write
    c = cyc;
    exp_q.push_back(mk(2'd0, P0, 1'b0, 16'h0, c + 16'd2));
    fork
      drive0(1'b1, 16'h0000, 16'hEE44, 1'b0);
      begin
        @(negedge clk);
        check("s1_issue_ctl", {30'd0, mem_write, mem_read}, 32'd2);
        check("s1_issue_addr", {16'd0, mem_address}, 32'h0000);
        check("s1_issue_data", {16'd0, mem_data_write}, 32'hEE44);
        check("s1_busy_gid", {30'd0, busy, grant_id}, 32'd2);
        @(negedge clk);
        check("s1_done_ctl", {30'd0, mem_write, mem_read}, 32'd0);
      end
    join
    @(negedge clk);

    // 2: port 1 read, READ_LAT=1
    c = cyc;
    exp_q.push_back(mk(2'd0, P1, 1'b1, 16'hEE44, c + 16'd3));
    fork
      drive1(1'b0, 16'h0000, 16'h0, 1'b0);
      begin
        @(negedge clk);
        check("s2_rd_c1", {31'd0, mem_read}, 32'd1);
        @(negedge clk);
        check("s2_rd_c2", {31'd0, mem_read}, 32'd1);
        check("s2_wait_state", {30'd0, dbg_state}, {30'd0, WAIT});
        @(negedge clk);
        check("s2_rd_c3", {31'd0, mem_read}, 32'd0);
      end
    join
    check("s2_rdata0_hold", {16'd0, rdata0}, 32'd0);
    @(negedge clk);

    // 3: simultaneous requests from reset, four transactions
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    c = cyc;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_q.push_back(mk(2'd0, P0, 1'b0, 16'h0, c + 16'd2));
    exp_q.push_back(mk(2'd0, P0, 1'b0, 16'h0, c + 16'd5));
    exp_q.push_back(mk(2'd0, P1, 1'b0, 16'h0, c + 16'd8));
    exp_q.push_back(mk(2'd0, P1, 1'b0, 16'h0, c + 16'd11));
`else
    exp_q.push_back(mk(2'd0, P0, 1'b0, 16'h0, c + 16'd2));
    exp_q.push_back(mk(2'd0, P1, 1'b0, 16'h0, c + 16'd5));
    exp_q.push_back(mk(2'd0, P0, 1'b0, 16'h0, c + 16'd8));
    exp_q.push_back(mk(2'd0, P1, 1'b0, 16'h0, c + 16'd11));
`endif
    fork
      begin drive0(1'b1, 16'h0010, 16'hA001, 1'b1); drive0(1'b1, 16'h0012, 16'hA002, 1'b0); end
      begin drive1(1'b1, 16'h0011, 16'hB001, 1'b1); drive1(1'b1, 16'h0013, 16'hB002, 1'b0); end
    join
    check("s3_mem_10", {16'd0, mem_a[8'h10]}, 32'hA001);
    check("s3_mem_13", {16'd0, mem_a[8'h13]}, 32'hB002);
    @(negedge clk);

    // 4: port 0 continuous, port 1 once
    c = cyc;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_q.push_back(mk(2'd0, P0, 1'b0, 16'h0, c + 16'd2));
    exp_q.push_back(mk(2'd0, P0, 1'b0, 16'h0, c + 16'd5));
    exp_q.push_back(mk(2'd0, P0, 1'b0, 16'h0, c + 16'd8));
    exp_q.push_back(mk(2'd0, P1, 1'b0, 16'h0, c + 16'd11));
`else
    exp_q.push_back(mk(2'd0, P0, 1'b0, 16'h0, c + 16'd2));
    exp_q.push_back(mk(2'd0, P1, 1'b0, 16'h0, c + 16'd5));
    exp_q.push_back(mk(2'd0, P0, 1'b0, 16'h0, c + 16'd8));
    exp_q.push_back(mk(2'd0, P0, 1'b0, 16'h0, c + 16'd11));
`endif
    fork
      begin
        drive0(1'b1, 16'h0020, 16'hC001, 1'b1);
        drive0(1'b1, 16'h0021, 16'hC002, 1'b1);
        drive0(1'b1, 16'h0022, 16'hC003, 1'b0);
      end
      begin @(negedge clk); drive1(1'b1, 16'h0002, 16'hFEE4, 1'b0); end
    join
    check("s4_mem_02", {16'd0, mem_a[8'h02]}, 32'hFEE4);
    @(negedge clk);
    c = cyc;
    exp_q.push_back(mk(2'd0, P0, 1'b1, 16'hFEE4, c + 16'd3));
    drive0(1'b0, 16'h0002, 16'h0, 1'b0);
    @(negedge clk);

    // 5: reset during WAIT of a port 0 read
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0002;
    @(negedge clk);
    @(negedge clk);
    check("s5_in_wait", {30'd0, dbg_state}, {30'd0, WAIT});
    rst = 1'b1;
    @(negedge clk);
    check("s5_abort_ctl", {29'd0, mem_read, busy, ack0}, 32'd0);
    check("s5_abort_state", {30'd0, dbg_state}, {30'd0, IDLE});
    check("s5_abort_addr", {16'd0, mem_address}, 32'd0);
    rst = 1'b0; req0 = 1'b0;
    @(negedge clk);
    c = cyc;
    exp_q.push_back(mk(2'd0, P0, 1'b1, 16'hFEE4, c + 16'd3));
    exp_q.push_back(mk(2'd0, P1, 1'b1, 16'hEE44, c + 16'd7));
    fork
      drive0(1'b0, 16'h0002, 16'h0, 1'b0);
      drive1(1'b0, 16'h0000, 16'h0, 1'b0);
    join
    @(negedge clk);

    // 6: READ_LAT=0 and READ_LAT=3 instances
    c = cyc;
    exp_q.push_back(mk(2'd1, P0, 1'b0, 16'h0, c + 16'd2));
    drive_x(1, 1'b1, 16'h0002, 16'hFEE4);
    @(negedge clk);
    c = cyc;
    exp_q.push_back(mk(2'd1, P0, 1'b1, 16'hFEE4, c + 16'd2));
    drive_x(1, 1'b0, 16'h0002, 16'h0);
    @(negedge clk);
    c = cyc;
    exp_q.push_back(mk(2'd2, P0, 1'b0, 16'h0, c + 16'd2));
    drive_x(2, 1'b1, 16'h0002, 16'hFEE4);
    @(negedge clk);
    c = cyc;
    exp_q.push_back(mk(2'd2, P0, 1'b1, 16'hFEE4, c + 16'd5));
    drive_x(2, 1'b0, 16'h0002, 16'h0);

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
